line_stepper: RTL and testbench

LINE_STEPPER -- requirements
Module: line_stepper

---
 rtl/gpu_pkg.sv | 14 +
 rtl/line_stepper_if.sv | 32 +++
 rtl/line_stepper_delta.sv | 16 +
 rtl/line_stepper.sv | 140 ++++++++++++++
 tb/tb_line_stepper.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types and default widths for the line-drawing datapath.
package gpu_pkg;

  localparam int unsigned COORD_W_DEF = 16;
  localparam int unsigned PAT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/line_stepper_if.sv
// Request / pixel-stream bundle between a line client and line_stepper.
interface line_stepper_if #(
  parameter int unsigned COORD_W = gpu_pkg::COORD_W_DEF,
  parameter int unsigned PAT_W   = gpu_pkg::PAT_W_DEF
);

  logic               start;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic [PAT_W-1:0]   pattern;
  logic               busy;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] x_o;
  logic [COORD_W-1:0] y_o;
  logic               pix_on;
  logic               last;
  logic               done;

  modport master (
    output start, x1, y1, x2, y2, pattern, pix_ready,
    input  busy, pix_valid, x_o, y_o, pix_on, last, done
  );

  modport slave (
    input  start, x1, y1, x2, y2, pattern, pix_ready,
    output busy, pix_valid, x_o, y_o, pix_on, last, done
  );

endinterface

// File: rtl/line_stepper_delta.sv
// Per-axis magnitude |b-a| (one extra bit) and direction (neg = stepping down).
module line_delta #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   mag,
  output logic         neg
);

  always_comb begin
    neg = (b < a);
    mag = neg ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  end

endmodule

// File: rtl/line_stepper.sv
// Bresenham line walker: latches endpoints and a dash mask, then streams one
// pixel per accepted handshake with a per-pixel pattern bit.
module line_stepper
  import gpu_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned PAT_W   = PAT_W_DEF
) (
  input logic           clk,
  input logic           n_rst,
  line_stepper_if.slave bus
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned ERR_W = COORD_W + 3;

  state_t state, state_next;

  logic [COORD_W-1:0] x1_l, y1_l, x2_l, y2_l;
  logic [PAT_W-1:0]   pat_l;
  logic [COORD_W-1:0] x, y;
  logic [COORD_W:0]   dx_w, dy_w, dx, dy;
  logic               neg_x_w, neg_y_w, neg_x, neg_y;
  logic signed [ERR_W-1:0] err;
  logic [IDX_W-1:0]   idx;

  logic               at_end;
  logic               fire;
  logic               step_x, step_y;
  logic signed [ERR_W:0]   e2;
  logic signed [ERR_W-1:0] dx_s, dy_s, sub_x, add_y, err_sum;

  line_delta #(.W(COORD_W)) u_delta_x (
    .a   (x1_l),
    .b   (x2_l),
    .mag (dx_w),
    .neg (neg_x_w)
  );

  line_delta #(.W(COORD_W)) u_delta_y (
    .a   (y1_l),
    .b   (y2_l),
    .mag (dy_w),
    .neg (neg_y_w)
  );

  assign at_end = (x == x2_l) && (y == y2_l);
  assign fire   = (state == STEP) && bus.pix_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = SETUP;
      SETUP:   state_next = STEP;
      STEP:    if (fire && at_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Both axis decisions use the same doubled error, so x and y can move together.
  always_comb begin
    dx_s    = $signed({2'b00, dx});
    dy_s    = $signed({2'b00, dy});
    e2      = $signed({err, 1'b0});
    step_x  = (e2 > -$signed({3'b000, dy}));
    step_y  = (e2 <  $signed({3'b000, dx}));
    sub_x   = step_x ? dy_s : '0;
    add_y   = step_y ? dx_s : '0;
    err_sum = err - sub_x + add_y;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x1_l  <= '0;
      y1_l  <= '0;
      x2_l  <= '0;
      y2_l  <= '0;
      pat_l <= '0;
      x     <= '0;
      y     <= '0;
      dx    <= '0;
      dy    <= '0;
      neg_x <= 1'b0;
      neg_y <= 1'b0;
      err   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            x1_l  <= bus.x1;
            y1_l  <= bus.y1;
            x2_l  <= bus.x2;
            y2_l  <= bus.y2;
            pat_l <= bus.pattern;
          end
        end
        SETUP: begin
          dx    <= dx_w;
          dy    <= dy_w;
          neg_x <= neg_x_w;
          neg_y <= neg_y_w;
          err   <= $signed({2'b00, dx_w}) - $signed({2'b00, dy_w});
          x     <= x1_l;
          y     <= y1_l;
          idx   <= '0;
        end
        STEP: begin
          if (bus.pix_ready) begin
            idx <= idx + IDX_W'(1);
            if (!at_end) begin
              err <= err_sum;
              if (step_x) x <= neg_x ? (x - COORD_W'(1)) : (x + COORD_W'(1));
              if (step_y) y <= neg_y ? (y - COORD_W'(1)) : (y + COORD_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.pix_valid = (state == STEP);
  assign bus.x_o       = x;
  assign bus.y_o       = y;
  assign bus.pix_on    = (state == STEP) && pat_l[idx];
  assign bus.last      = (state == STEP) && at_end;
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_line_stepper.sv
// Self-checking bench for line_stepper: directed table, hand sequences and
// random lines compared against an integer Bresenham reference.
module tb_line_stepper;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  line_stepper_if #(.COORD_W(16), .PAT_W(16)) bus ();

  line_stepper #(.COORD_W(16), .PAT_W(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x1, y1, x2, y2;
    int n;
    int px[8];
    int py[8];
  } vec_t;

  vec_t tbl[4];

  logic [15:0] cap_x[$], cap_y[$], exp_x[$], exp_y[$];
  bit          cap_on[$], cap_last[$], exp_on[$], exp_last[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void build_model(int ax1, int ay1, int ax2, int ay2, logic [15:0] pat);
    int dx, dy, sx, sy, err, e2, x, y, i;
    exp_x.delete(); exp_y.delete(); exp_on.delete(); exp_last.delete();
    dx = iabs(ax2 - ax1);
    dy = iabs(ay2 - ay1);
    sx = (ax2 >= ax1) ? 1 : -1;
    sy = (ay2 >= ay1) ? 1 : -1;
    err = dx - dy;
    x = ax1;
    y = ay1;
    i = 0;
    for (int g = 0; g < 70000; g++) begin
      exp_x.push_back(x[15:0]);
      exp_y.push_back(y[15:0]);
      exp_on.push_back(pat[i % 16]);
      exp_last.push_back(x == ax2 && y == ay2);
      if (x == ax2 && y == ay2) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
      i++;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  bus.busy,      1'b0);
    check({tag, "_valid"}, bus.pix_valid, 1'b0);
    check({tag, "_flags"}, {bus.last, bus.done, bus.pix_on}, 3'b000);
    check({tag, "_xy"},    {bus.x_o, bus.y_o}, 32'h0);
  endtask

  // Drives one line from IDLE to IDLE; stall_at >= 0 holds ready low for 3 cycles on that pixel.
  task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                          input logic [15:0] pat, input int stall_at,
                          input bit rand_rdy, input bit poke);
    int          stall_cnt, mi, n_need;
    bit          fin, rdy;
    logic [15:0] hx, hy;
    logic        hon, hlast;

    build_model(ax1, ay1, ax2, ay2, pat);
    n_need = (iabs(ax2 - ax1) > iabs(ay2 - ay1)) ? iabs(ax2 - ax1) + 1 : iabs(ay2 - ay1) + 1;
    cap_x.delete(); cap_y.delete(); cap_on.delete(); cap_last.delete();

    @(negedge clk);
    bus.x1 = ax1[15:0]; bus.y1 = ay1[15:0];
    bus.x2 = ax2[15:0]; bus.y2 = ay2[15:0];
    bus.pattern = pat;
    bus.start = 1'b1;
    bus.pix_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x1 = 16'($urandom); bus.y1 = 16'($urandom);
    bus.x2 = 16'($urandom); bus.y2 = 16'($urandom);
    bus.pattern = 16'($urandom);
    check("setup_busy",  bus.busy, 1'b1);
    check("setup_valid", bus.pix_valid, 1'b0);
    @(negedge clk);
    check("first_valid", bus.pix_valid, 1'b1);
    check("first_pixel", {bus.x_o, bus.y_o}, {ax1[15:0], ay1[15:0]});

    stall_cnt = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 70000 && !fin && cap_x.size() <= n_need; cyc++) begin
      bus.start = poke && (cyc == 1);
      rdy = 1'b0;
      if (bus.pix_valid) begin
        rdy = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        if (cap_x.size() == stall_at && stall_cnt <= 3) begin
          if (stall_cnt == 0) {hx, hy, hon, hlast} = {bus.x_o, bus.y_o, bus.pix_on, bus.last};
          else check("stall_hold", {bus.x_o, bus.y_o, bus.pix_on, bus.last}, {hx, hy, hon, hlast});
          rdy = (stall_cnt == 3);
          stall_cnt++;
        end
        if (rdy) begin
          cap_x.push_back(bus.x_o);
          cap_y.push_back(bus.y_o);
          cap_on.push_back(bus.pix_on);
          cap_last.push_back(bus.last);
          if (bus.last) fin = 1'b1;
        end
      end
      bus.pix_ready = rdy;
      @(negedge clk);
    end
    bus.pix_ready = 1'b0;
    bus.start = 1'b0;
    check("line_finished", fin, 1'b1);
    check("done_pulse", {bus.done, bus.pix_valid, bus.busy}, 3'b101);
    @(negedge clk);
    check("done_clear", {bus.done, bus.busy}, 2'b00);

    mi = -1;
    for (int j = 0; j < cap_x.size() && j < exp_x.size(); j++)
      if (mi < 0 && (cap_x[j] !== exp_x[j] || cap_y[j] !== exp_y[j] ||
                     cap_on[j] !== exp_on[j] || cap_last[j] !== exp_last[j])) mi = j;
    if (mi < 0 && cap_x.size() != exp_x.size())
      mi = (cap_x.size() < exp_x.size()) ? cap_x.size() : exp_x.size();
    check("pixel_seq_first_bad", mi, -1);
    check("pixel_count", cap_x.size(), n_need);
  endtask

  initial begin
    int d, x1, y1, x2, y2, ok;
    int pv[4];
    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.pix_ready = 1'b0;
    bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
    bus.pattern = '0;

    tbl[0].x1 = 0; tbl[0].y1 = 0; tbl[0].x2 = 4; tbl[0].y2 = 0; tbl[0].n = 5;
    tbl[0].px = '{0, 1, 2, 3, 4, 0, 0, 0};
    tbl[0].py = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].x1 = 0; tbl[1].y1 = 0; tbl[1].x2 = 2; tbl[1].y2 = 5; tbl[1].n = 6;
    tbl[1].px = '{0, 0, 1, 1, 2, 2, 0, 0};
    tbl[1].py = '{0, 1, 2, 3, 4, 5, 0, 0};
    tbl[2].x1 = 3; tbl[2].y1 = 3; tbl[2].x2 = 0; tbl[2].y2 = 0; tbl[2].n = 4;
    tbl[2].px = '{3, 2, 1, 0, 0, 0, 0, 0};
    tbl[2].py = '{3, 2, 1, 0, 0, 0, 0, 0};
    tbl[3].x1 = 7; tbl[3].y1 = 7; tbl[3].x2 = 7; tbl[3].y2 = 7; tbl[3].n = 1;
    tbl[3].px = '{7, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].py = '{7, 0, 0, 0, 0, 0, 0, 0};
    pv = '{0, 1, 0, 1};

    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #2 n_rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_line(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, 16'hFFFF, -1, 1'b0, 1'b0);
      check("tbl_count", cap_x.size(), tbl[i].n);
      ok = 1;
      for (int j = 0; j < tbl[i].n && j < cap_x.size(); j++)
        if (cap_x[j] != tbl[i].px[j][15:0] || cap_y[j] != tbl[i].py[j][15:0] ||
            cap_last[j] != (j == tbl[i].n - 1)) ok = 0;
      check("tbl_pixels", ok, 1);
    end

    // Backpressure on the third pixel.
    run_line(0, 0, 5, 2, 16'h5A5A, 2, 1'b0, 1'b0);

    // Dash mask with a start pulse while busy.
    run_line(0, 0, 3, 0, 16'hAAAA, -1, 1'b0, 1'b1);
    for (int j = 0; j < 4 && j < cap_on.size(); j++)
      check("pattern_bit", cap_on[j], pv[j][0]);

    // Reset in the middle of a line.
    @(negedge clk);
    bus.x1 = 16'd0; bus.y1 = 16'd0; bus.x2 = 16'd10; bus.y2 = 16'd0;
    bus.pattern = 16'hFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("midline_active", {bus.busy, bus.pix_valid, bus.pix_on}, 3'b111);
    #2 n_rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bus.pix_ready = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b1;
    run_line(2, 1, 6, 3, 16'h0F0F, -1, 1'b0, 1'b0);

    // Full-range shallow line.
    run_line(0, 0, 65535, 3, 16'h1234, -1, 1'b0, 1'b0);

    // Random short lines anywhere in the coordinate space, random ready.
    for (int r = 0; r < 25; r++) begin
      x1 = $urandom_range(65535);
      y1 = $urandom_range(65535);
      d  = $urandom_range(40);
      x2 = ($urandom_range(1) == 1) ? x1 + d : x1 - d;
      d  = $urandom_range(40);
      y2 = ($urandom_range(1) == 1) ? y1 + d : y1 - d;
      if (x2 < 0) x2 = 0;
      if (x2 > 65535) x2 = 65535;
      if (y2 < 0) y2 = 0;
      if (y2 > 65535) y2 = 65535;
      run_line(x1, y1, x2, y2, 16'($urandom), -1, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
